// File: rtl/video_timing_pkg.sv
// Shared timing constants and transmitter state encoding for the video stream path.
package video_timing_pkg;

  localparam int unsigned HFront  = 7;
  localparam int unsigned HSync   = 23;
  localparam int unsigned HBack   = 23;
  localparam int unsigned VBottom = 14;
  localparam int unsigned VSync   = 3;
  localparam int unsigned VTop    = 5;

  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2
  } tx_state_e;

endpackage

// File: rtl/pixel_fifo.sv
// Count-based synchronous FIFO holding {sof, colour} pixel words.
module pixel_fifo #(
  parameter int unsigned Width = 4,
  parameter int unsigned Depth = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] DepthCnt = (AW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == DepthCnt);
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - (AW + 1)'(1);
    end
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/video_stream_tx.sv
// Streams buffered pixels onto a raster with sync generation and frame realignment on sof.
module video_stream_tx
  import video_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY  = 256,
  parameter int unsigned V_DISPLAY  = 240,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] pix_data,
  input  logic       pix_sof,
  input  logic       pix_valid,
  output logic       pix_ready,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb,
  output logic [8:0] hpos,
  output logic [8:0] vpos,
  output logic       underflow
);

  localparam logic [8:0] HDisp      = 9'(H_DISPLAY);
  localparam logic [8:0] VDisp      = 9'(V_DISPLAY);
  localparam logic [8:0] HMax       = 9'(H_DISPLAY + HFront + HSync + HBack - 1);
  localparam logic [8:0] VMax       = 9'(V_DISPLAY + VBottom + VSync + VTop - 1);
  localparam logic [8:0] HSyncStart = 9'(H_DISPLAY + HFront);
  localparam logic [8:0] HSyncEnd   = 9'(H_DISPLAY + HFront + HSync - 1);
  localparam logic [8:0] VSyncStart = 9'(V_DISPLAY + VBottom);
  localparam logic [8:0] VSyncEnd   = 9'(V_DISPLAY + VBottom + VSync - 1);

  tx_state_e  state_q, state_d;
  logic [8:0] hpos_q, hpos_d, vpos_q, vpos_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d;
  logic       underflow_q, underflow_d;
  logic [2:0] rgb_q, rgb_d;

  logic       fifo_full, fifo_empty, fifo_pop;
  logic [3:0] fifo_head;
  logic       display_on, at_origin, frame_end, serving;

  pixel_fifo #(
    .Width (4),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (pix_valid),
    .wdata_i ({pix_sof, pix_data}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign pix_ready  = ~fifo_full;
  assign display_on = (hpos_q < HDisp) && (vpos_q < VDisp);
  assign at_origin  = (hpos_q == '0) && (vpos_q == '0);
  assign frame_end  = (hpos_q == '0) && (vpos_q == VDisp);
  // ARMED serves the origin pixel itself so the first pixel lands on hpos=0,vpos=0.
  assign serving    = (state_q == ACTIVE) || ((state_q == ARMED) && at_origin);

  always_comb begin
    hpos_d = hpos_q + 9'd1;
    vpos_d = vpos_q;
    if (hpos_q == HMax) begin
      hpos_d = '0;
      vpos_d = (vpos_q == VMax) ? '0 : vpos_q + 9'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      SEEK: begin
        if (!fifo_empty) begin
          if (!fifo_head[3]) begin
            fifo_pop = 1'b1;
          end else if (!at_origin) begin
            state_d = ARMED;
          end
        end
      end
      ARMED: begin
        if (at_origin) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (frame_end) state_d = SEEK;
      end
      default: state_d = SEEK;
    endcase
    if (serving && display_on && !fifo_empty) fifo_pop = 1'b1;
  end

  always_comb begin
    rgb_d       = (serving && display_on && !fifo_empty) ? fifo_head[2:0] : 3'd0;
    hsync_d     = !((hpos_q >= HSyncStart) && (hpos_q <= HSyncEnd));
    vsync_d     = !((vpos_q >= VSyncStart) && (vpos_q <= VSyncEnd));
    underflow_d = underflow_q;
    if (serving && display_on && fifo_empty) begin
      underflow_d = 1'b1;
    end else if (at_origin) begin
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SEEK;
      hpos_q      <= '0;
      vpos_q      <= '0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      rgb_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hpos_q      <= hpos_d;
      vpos_q      <= vpos_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      rgb_q       <= rgb_d;
      underflow_q <= underflow_d;
    end
  end

  assign hpos      = hpos_q;
  assign vpos      = vpos_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign rgb       = rgb_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_video_stream_tx.sv
// Directed bench for video_stream_tx on a reduced 16x8 raster (69x30 total).
module tb_video_stream_tx;

  localparam int H     = 16;
  localparam int V     = 8;
  localparam int HT    = H + 53;
  localparam int VT    = V + 22;
  localparam int FRAME = HT * VT;
  localparam int TMO   = 3 * FRAME;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] pix_data = '0;
  logic       pix_sof = 1'b0;
  logic       pix_valid = 1'b0;
  logic       pix_ready, hsync, vsync, underflow;
  logic [2:0] rgb;
  logic [8:0] hpos, vpos;

  video_stream_tx #(
    .H_DISPLAY  (H),
    .V_DISPLAY  (V),
    .FIFO_DEPTH (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pix_data  (pix_data),
    .pix_sof   (pix_sof),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .hsync     (hsync),
    .vsync     (vsync),
    .rgb       (rgb),
    .hpos      (hpos),
    .vpos      (vpos),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Reference raster position: m* is the counter now, p* the one a cycle ago.
  int mh = 0, mv = 0, mf = 0, ph = 0, pv = 0, pf = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mh <= 0;
      mv <= 0;
      ph <= 0;
      pv <= 0;
    end else begin
      ph <= mh;
      pv <= mv;
      pf <= mf;
      if (mh == HT - 1) begin
        mh <= 0;
        if (mv == VT - 1) begin
          mv <= 0;
          mf <= mf + 1;
        end else begin
          mv <= mv + 1;
        end
      end else begin
        mh <= mh + 1;
      end
    end
  end

  // Expected-picture description for one frame; every other frame must be black.
  bit         chk_en = 1'b0;
  int         pat_frame = -1;
  int         pat_mode = 0;
  int         stall = 0;
  int         lst_n = 0;
  logic [2:0] lst [16];

  function automatic logic [2:0] exp_rgb();
    int idx;
    if (pf != pat_frame || ph >= H || pv >= V) return 3'd0;
    idx = pv * H + ph;
    if (pat_mode == 1) return (idx < stall) ? 3'((ph + pv) % 8) : 3'd0;
    return (idx < lst_n) ? lst[idx] : 3'd0;
  endfunction

  int ctr_err = 0, sync_err = 0, rgb_err = 0, hs_low = 0, vs_low = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (hpos != 9'(mh) || vpos != 9'(mv)) ctr_err <= ctr_err + 1;
      if (hsync != !(ph >= H + 7 && ph <= H + 29) || vsync != !(pv >= V + 14 && pv <= V + 16))
        sync_err <= sync_err + 1;
      if (!hsync) hs_low <= hs_low + 1;
      if (!vsync) vs_low <= vs_low + 1;
      if (chk_en && rgb != exp_rgb()) rgb_err <= rgb_err + 1;
    end
  end

  task automatic wait_cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_at(input int h, input int v);
    int n = 0;
    do begin
      wait_cyc();
      n++;
    end while (!(mh == h && mv == v) && n < TMO);
    if (n >= TMO) check("wait_position", mh * 1000 + mv, h * 1000 + v);
  endtask

  task automatic push_word(input logic [2:0] c, input logic s);
    int n = 0;
    pix_valid = 1'b1;
    pix_data  = c;
    pix_sof   = s;
    while (!pix_ready && n < TMO) begin
      wait_cyc();
      n++;
    end
    if (n >= TMO) check("push_timeout", int'(pix_ready), 1);
    wait_cyc();
    pix_valid = 1'b0;
  endtask

  task automatic stream(input int nw);
    for (int k = 0; k < nw; k++) push_word(3'(((k % H) + (k / H)) % 8), k == 0);
  endtask

  // Holds valid for 20 cycles with nothing popping; exactly 16 words must be taken.
  task automatic fill_armed();
    int i = 0;
    int acc = 0;
    for (int c = 0; c < 20; c++) begin
      pix_valid = 1'b1;
      pix_data  = lst[i & 15];
      pix_sof   = (i == 0);
      if (pix_ready) begin
        acc++;
        i++;
      end
      wait_cyc();
    end
    pix_valid = 1'b0;
    check("armed_accepts", acc, 16);
    check("armed_ready_low", int'(pix_ready), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_hpos"}, int'(hpos), 0);
    check({tag, "_vpos"}, int'(vpos), 0);
    check({tag, "_hsync"}, int'(hsync), 1);
    check({tag, "_vsync"}, int'(vsync), 1);
    check({tag, "_rgb"}, int'(rgb), 0);
    check({tag, "_underflow"}, int'(underflow), 0);
    check({tag, "_ready"}, int'(pix_ready), 1);
  endtask

  int b_hs, b_vs, b_rgb;

  initial begin
    repeat (3) wait_cyc();
    check_reset_values("reset");
    reset  = 1'b0;
    chk_en = 1'b1;

    // Idle producer: sync boundaries, counter wrap, one frame of sync counts.
    wait_at(H + 7, 0);
    check("hsync_before_start", int'(hsync), 1);
    wait_cyc();
    check("hsync_first_low", int'(hsync), 0);
    wait_at(HT - 1, 0);
    check("hpos_max", int'(hpos), HT - 1);
    wait_cyc();
    check("hpos_wrap", int'(hpos), 0);
    check("vpos_step", int'(vpos), 1);
    b_hs  = hs_low;
    b_vs  = vs_low;
    b_rgb = rgb_err;
    repeat (FRAME) wait_cyc();
    check("hsync_low_per_frame", hs_low - b_hs, 23 * VT);
    check("vsync_low_per_frame", vs_low - b_vs, 3 * HT);
    check("idle_rgb_errors", rgb_err - b_rgb, 0);
    check("idle_underflow", int'(underflow), 0);
    wait_at(HT - 1, VT - 1);
    wait_cyc();
    check("vpos_wrap", int'(vpos), 0);

    // Three non-sof words are discarded; the sof word lands on the origin pixel.
    wait_at(0, V + 1);
    lst[0]    = 3'd5;
    lst_n     = 1;
    pat_mode  = 2;
    pat_frame = mf + 1;
    b_rgb     = rgb_err;
    push_word(3'd1, 1'b0);
    push_word(3'd2, 1'b0);
    push_word(3'd3, 1'b0);
    push_word(3'd5, 1'b1);
    wait_at(1, 0);
    check("sof_first_pixel", int'(rgb), 5);
    check("sof_no_underflow", int'(underflow), 0);
    wait_cyc();
    check("empty_pixel_black", int'(rgb), 0);
    check("underflow_set", int'(underflow), 1);
    wait_at(0, V);
    check("underflow_sticky", int'(underflow), 1);
    check("sof_frame_rgb", rgb_err - b_rgb, 0);

    // Full frame with an always-valid producer.
    wait_at(0, V + 1);
    pat_mode  = 1;
    stall     = H * V;
    pat_frame = mf + 1;
    b_rgb     = rgb_err;
    stream(H * V);
    wait_at(0, V);
    check("full_frame_rgb", rgb_err - b_rgb, 0);
    check("full_frame_underflow", int'(underflow), 0);

    // Producer stops at pixel 10 of line 5.
    wait_at(0, V + 1);
    stall     = 5 * H + 10;
    pat_frame = mf + 1;
    b_rgb     = rgb_err;
    stream(5 * H + 10);
    wait_at(0, V);
    check("stall_frame_rgb", rgb_err - b_rgb, 0);
    check("stall_underflow", int'(underflow), 1);

    // Next sof realigns and the sticky flag clears.
    wait_at(0, V + 1);
    stall     = H * V;
    pat_frame = mf + 1;
    b_rgb     = rgb_err;
    stream(H * V);
    wait_at(0, V);
    check("realign_rgb", rgb_err - b_rgb, 0);
    check("realign_underflow", int'(underflow), 0);

    // ARMED backpressure: 16 words held, then shown in order.
    wait_at(0, V + 2);
    for (int i = 0; i < 16; i++) lst[i] = 3'((i * 3 + 1) % 8);
    lst_n     = 16;
    pat_mode  = 2;
    pat_frame = mf + 1;
    b_rgb     = rgb_err;
    fill_armed();
    wait_at(H + 1, 3);
    check("armed_rgb", rgb_err - b_rgb, 0);
    check("armed_underflow", int'(underflow), 1);

    // Mid-frame reset with a partly full FIFO.
    chk_en = 1'b0;
    for (int i = 0; i < 11; i++) push_word(3'd6, 1'b1);
    wait_at(3, 4);
    check("pre_reset_rgb", int'(rgb), 6);
    check("pre_reset_underflow", int'(underflow), 1);
    reset = 1'b1;
    #1;
    check_reset_values("midreset");
    repeat (2) wait_cyc();
    reset     = 1'b0;
    pat_frame = mf + 1;
    b_rgb     = rgb_err;
    chk_en    = 1'b1;
    wait_cyc();
    fill_armed();
    wait_at(0, V);
    check("no_stale_rgb", rgb_err - b_rgb, 0);
    wait_at(0, V);
    check("post_reset_rgb", rgb_err - b_rgb, 0);
    check("post_reset_underflow", int'(underflow), 1);

    check("counter_errors", ctr_err, 0);
    check("sync_errors", sync_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
